// File: rtl/hazard_tracker_pkg.sv
// Shared constants, stage record types and hazard helpers for the hazard tracker.
package hazard_tracker_pkg;

    localparam int          MD_MULT_CYC = 5;
    localparam int          MD_DIV_CYC  = 10;
    localparam int          MD_CNT_W    = 4;
    localparam logic [1:0]  TUSE_NONE   = 2'd3;

    // Producer record carried by the E and M stages.
    typedef struct packed {
        logic [4:0] a3;
        logic       regwr;
        logic [1:0] tnew;
    } stage_rec_t;

    // Write-back record; the result is already available, so there is no Tnew.
    typedef struct packed {
        logic [4:0] a3;
        logic       regwr;
    } wb_rec_t;

    // One stage closer to ready, floored at zero.
    function automatic logic [1:0] tnew_dec(input logic [1:0] t);
        return (t == 2'd0) ? 2'd0 : t - 2'd1;
    endfunction

    // A source operand hazards when an in-flight producer of the same nonzero
    // register cannot forward in time for this consumer.
    function automatic logic src_hazard(input logic [4:0] a, input logic [1:0] tuse,
                                        input stage_rec_t e, input stage_rec_t m);
        return (a != 5'd0) &&
               ((a == e.a3 && e.regwr && tuse < e.tnew) ||
                (a == m.a3 && m.regwr && tuse < m.tnew));
    endfunction

endpackage

// File: rtl/hazard_tracker_if.sv
// Decode-stage hazard query and per-stage producer status.
interface hazard_tracker_if;
    logic [4:0] A1_D;
    logic [4:0] A2_D;
    logic [1:0] Tuse_rs_D;
    logic [1:0] Tuse_rt_D;
    logic [4:0] A3_D;
    logic       RegWr_D;
    logic [1:0] Tnew_D;
    logic       md_start_D;
    logic       md_div_D;
    logic       md_use_D;

    logic       stall;
    logic [4:0] A3_E, A3_M, A3_W;
    logic       RegWr_E, RegWr_M, RegWr_W;
    logic [1:0] T_new_E, T_new_M;
    logic       md_busy;

    modport master (
        output A1_D, A2_D, Tuse_rs_D, Tuse_rt_D, A3_D, RegWr_D, Tnew_D,
               md_start_D, md_div_D, md_use_D,
        input  stall, A3_E, A3_M, A3_W, RegWr_E, RegWr_M, RegWr_W,
               T_new_E, T_new_M, md_busy
    );

    modport slave (
        input  A1_D, A2_D, Tuse_rs_D, Tuse_rt_D, A3_D, RegWr_D, Tnew_D,
               md_start_D, md_div_D, md_use_D,
        output stall, A3_E, A3_M, A3_W, RegWr_E, RegWr_M, RegWr_W,
               T_new_E, T_new_M, md_busy
    );
endinterface

// File: rtl/hazard_tracker_md_busy_ctr.sv
// Multiply/divide busy counter: loads the op latency on start, counts down to idle.
module md_busy_ctr
    import hazard_tracker_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  logic start,
    input  logic div,
    output logic busy
);

    logic [MD_CNT_W-1:0] md_cnt;

    // Load latency on start, otherwise drain toward zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            md_cnt <= '0;
        else if (start)
            md_cnt <= div ? MD_CNT_W'(MD_DIV_CYC) : MD_CNT_W'(MD_MULT_CYC);
        else if (md_cnt != '0)
            md_cnt <= md_cnt - 1'b1;
    end

    assign busy = (md_cnt != '0);

endmodule

// File: rtl/hazard_tracker.sv
// Tracks in-flight GPR producers and the HI/LO unit to decide decode-stage stalls.
module hazard_tracker
    import hazard_tracker_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    hazard_tracker_if.slave  hif
);

    stage_rec_t rec_e, rec_m;
    wb_rec_t    rec_w;
    logic       md_start_e, md_div_e;
    logic       md_busy;
    logic       rs_hz, rt_hz, md_hz, stall;

    // Zero-latency stall decision from D operands and registered stage state.
    always_comb begin
        rs_hz = src_hazard(hif.A1_D, hif.Tuse_rs_D, rec_e, rec_m);
        rt_hz = src_hazard(hif.A2_D, hif.Tuse_rt_D, rec_e, rec_m);
        // A HI/LO user waits through the launch cycle and every busy cycle.
        md_hz = hif.md_use_D & (md_busy | md_start_e);
        stall = rs_hz | rt_hz | md_hz;
    end

    // Advance stage records; a stalled D instruction leaves a bubble in E.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rec_e      <= '0;
            rec_m      <= '0;
            rec_w      <= '0;
            md_start_e <= 1'b0;
            md_div_e   <= 1'b0;
        end else begin
            rec_e      <= stall ? '0 : stage_rec_t'{a3: hif.A3_D, regwr: hif.RegWr_D, tnew: hif.Tnew_D};
            rec_m      <= '{a3: rec_e.a3, regwr: rec_e.regwr, tnew: tnew_dec(rec_e.tnew)};
            rec_w      <= '{a3: rec_m.a3, regwr: rec_m.regwr};
            md_start_e <= hif.md_start_D & ~stall;
            md_div_e   <= hif.md_div_D;
        end
    end

    md_busy_ctr u_md_busy_ctr (
        .clk   (clk),
        .rst_n (rst_n),
        .start (md_start_e),
        .div   (md_div_e),
        .busy  (md_busy)
    );

    assign hif.stall   = stall;
    assign hif.md_busy = md_busy;
    assign hif.A3_E    = rec_e.a3;
    assign hif.A3_M    = rec_m.a3;
    assign hif.A3_W    = rec_w.a3;
    assign hif.RegWr_E = rec_e.regwr;
    assign hif.RegWr_M = rec_m.regwr;
    assign hif.RegWr_W = rec_w.regwr;
    assign hif.T_new_E = rec_e.tnew;
    assign hif.T_new_M = rec_m.tnew;

endmodule

// File: tb/tb_hazard_tracker.sv
// Directed bench for hazard_tracker: load-use, branch, $0, md unit and reset cases.
module tb_hazard_tracker;

    logic clk = 1'b0;
    logic rst_n;
    int   checks = 0;
    int   errors = 0;

    hazard_tracker_if hif();

    hazard_tracker dut (
        .clk   (clk),
        .rst_n (rst_n),
        .hif   (hif)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_d(input logic [4:0] a1, input logic [1:0] tu1,
                         input logic [4:0] a2, input logic [1:0] tu2,
                         input logic [4:0] a3, input logic rw, input logic [1:0] tn,
                         input logic ms, input logic md, input logic mu);
        hif.A1_D = a1;  hif.Tuse_rs_D = tu1;
        hif.A2_D = a2;  hif.Tuse_rt_D = tu2;
        hif.A3_D = a3;  hif.RegWr_D = rw;  hif.Tnew_D = tn;
        hif.md_start_D = ms;  hif.md_div_D = md;  hif.md_use_D = mu;
    endtask

    task automatic nop();
        set_d(5'd0, 2'd3, 5'd0, 2'd3, 5'd0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic flush();
        nop();
        repeat (3) tick();
    endtask

    initial begin
        // Reset state
        rst_n = 1'b0;
        nop();
        #12;
        chk("reset_all", 32'({hif.A3_E, hif.A3_M, hif.A3_W, hif.RegWr_E, hif.RegWr_M, hif.RegWr_W,
                              hif.T_new_E, hif.T_new_M, hif.stall, hif.md_busy}), 32'd0);
        rst_n = 1'b1;
        tick();

        // Load-use: lw $8 then add $10,$8,$9 -> one stall
        set_d(5'd29, 2'd1, 5'd0, 2'd3, 5'd8, 1'b1, 2'd2, 1'b0, 1'b0, 1'b0);
        #1 chk("lu_lw_nostall", 32'(hif.stall), 32'd0);
        tick();
        set_d(5'd8, 2'd1, 5'd9, 2'd1, 5'd10, 1'b1, 2'd1, 1'b0, 1'b0, 1'b0);
        #1 chk("lu_stall", 32'(hif.stall), 32'd1);
        chk("lu_tnew_e", 32'(hif.T_new_E), 32'd2);
        tick();
        #1 chk("lu_bubble", 32'({hif.A3_E, hif.RegWr_E, hif.T_new_E}), 32'd0);
        chk("lu_m_rec", 32'({hif.A3_M, hif.T_new_M}), {25'd0, 5'd8, 2'd1});
        chk("lu_release", 32'(hif.stall), 32'd0);
        tick();
        nop();
        #1 chk("lu_tnew_m0", 32'(hif.T_new_M), 32'd0);
        chk("lu_w_rec", 32'({hif.A3_W, hif.RegWr_W}), {26'd0, 5'd8, 1'b1});
        chk("lu_e_add", 32'(hif.A3_E), 32'd10);
        flush();

        // Branch after ALU: addu $9 then beq $9 -> one stall
        set_d(5'd1, 2'd1, 5'd2, 2'd1, 5'd9, 1'b1, 2'd1, 1'b0, 1'b0, 1'b0);
        tick();
        set_d(5'd9, 2'd0, 5'd0, 2'd0, 5'd0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0);
        #1 chk("br_alu_stall", 32'(hif.stall), 32'd1);
        tick();
        #1 chk("br_alu_release", 32'(hif.stall), 32'd0);
        flush();

        // Branch after lw $11 -> two stalls
        set_d(5'd29, 2'd1, 5'd0, 2'd3, 5'd11, 1'b1, 2'd2, 1'b0, 1'b0, 1'b0);
        tick();
        set_d(5'd11, 2'd0, 5'd0, 2'd0, 5'd0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0);
        #1 chk("br_lw_stall1", 32'(hif.stall), 32'd1);
        tick();
        #1 chk("br_lw_stall2", 32'(hif.stall), 32'd1);
        tick();
        #1 chk("br_lw_release", 32'(hif.stall), 32'd0);
        flush();

        // rt hazard: addu $14 then beq $5,$14
        set_d(5'd1, 2'd1, 5'd2, 2'd1, 5'd14, 1'b1, 2'd1, 1'b0, 1'b0, 1'b0);
        tick();
        set_d(5'd5, 2'd0, 5'd14, 2'd0, 5'd0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0);
        #1 chk("rt_stall", 32'(hif.stall), 32'd1);
        tick();
        #1 chk("rt_release", 32'(hif.stall), 32'd0);
        flush();

        // $0 destination never hazards
        set_d(5'd29, 2'd1, 5'd0, 2'd3, 5'd0, 1'b1, 2'd2, 1'b0, 1'b0, 1'b0);
        tick();
        set_d(5'd0, 2'd1, 5'd0, 2'd0, 5'd0, 1'b1, 2'd1, 1'b0, 1'b0, 1'b0);
        #1 chk("zero_e", 32'(hif.stall), 32'd0);
        tick();
        #1 chk("zero_m", 32'(hif.stall), 32'd0);
        flush();

        // Independent sw after lw $12; store data at Tuse=2 against lw is also safe
        set_d(5'd29, 2'd1, 5'd0, 2'd3, 5'd12, 1'b1, 2'd2, 1'b0, 1'b0, 1'b0);
        tick();
        set_d(5'd29, 2'd1, 5'd13, 2'd2, 5'd0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0);
        #1 chk("sw_indep", 32'(hif.stall), 32'd0);
        chk("sw_a3e", 32'(hif.A3_E), 32'd12);
        tick();
        nop();
        #1 chk("sw_a3m", 32'({hif.A3_E, hif.A3_M}), {22'd0, 5'd0, 5'd12});
        tick();
        #1 chk("sw_a3w", 32'({hif.A3_M, hif.A3_W}), {22'd0, 5'd0, 5'd12});
        set_d(5'd29, 2'd1, 5'd12, 2'd2, 5'd0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0);
        flush();

        // div then mfhi -> 11 stall cycles
        set_d(5'd4, 2'd1, 5'd5, 2'd1, 5'd0, 1'b0, 2'd0, 1'b1, 1'b1, 1'b1);
        #1 chk("div_issue", 32'(hif.stall), 32'd0);
        tick();
        set_d(5'd0, 2'd3, 5'd0, 2'd3, 5'd2, 1'b1, 2'd1, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 11; i++) begin
            #1 chk($sformatf("div_stall_%0d", i), 32'(hif.stall), 32'd1);
            chk($sformatf("div_busy_%0d", i), 32'(hif.md_busy), (i == 0) ? 32'd0 : 32'd1);
            tick();
        end
        #1 chk("div_release", 32'({hif.stall, hif.md_busy}), 32'd0);
        flush();

        // mult then mflo -> 6 stall cycles
        set_d(5'd4, 2'd1, 5'd5, 2'd1, 5'd0, 1'b0, 2'd0, 1'b1, 1'b0, 1'b1);
        #1 chk("mult_issue", 32'(hif.stall), 32'd0);
        tick();
        set_d(5'd0, 2'd3, 5'd0, 2'd3, 5'd3, 1'b1, 2'd1, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 6; i++) begin
            #1 chk($sformatf("mult_stall_%0d", i), 32'(hif.stall), 32'd1);
            tick();
        end
        #1 chk("mult_release", 32'(hif.stall), 32'd0);
        flush();

        // Reset while dividing at md_cnt=6
        set_d(5'd4, 2'd1, 5'd5, 2'd1, 5'd0, 1'b0, 2'd0, 1'b1, 1'b1, 1'b1);
        tick();
        set_d(5'd1, 2'd1, 5'd2, 2'd1, 5'd7, 1'b1, 2'd1, 1'b0, 1'b0, 1'b0);
        repeat (5) tick();
        set_d(5'd0, 2'd3, 5'd0, 2'd3, 5'd2, 1'b1, 2'd1, 1'b0, 1'b0, 1'b1);
        #1 chk("rst_pre_stall", 32'({hif.stall, hif.md_busy}), 32'd3);
        chk("rst_pre_a3w", 32'(hif.A3_W), 32'd7);
        rst_n = 1'b0;
        #1 chk("rst_async_all", 32'({hif.A3_E, hif.A3_M, hif.A3_W, hif.RegWr_E, hif.RegWr_M, hif.RegWr_W,
                                     hif.T_new_E, hif.T_new_M, hif.stall, hif.md_busy}), 32'd0);
        #2 rst_n = 1'b1;
        #1 chk("rst_mfhi_free", 32'(hif.stall), 32'd0);
        tick();
        #1 chk("rst_after_edge", 32'({hif.stall, hif.md_busy}), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
